// File: rtl/apb_spi_fifo_regs.sv
// APB register slave for the SPI core: CR1/CR2/BR/SR/LVL/DR with TX/RX FIFOs behind DR.
// Latency: 2+WAIT_STATES cycles per APB transfer; register/FIFO effects visible the cycle after completion.
// Backpressure: PREADY held low for WAIT_STATES access cycles; full TX / empty RX on DR returns PSLVERR.
module apb_spi_fifo_regs #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [2:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic              spe,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  input  logic              wait_req,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tip,
  output logic              spi_interrupt_request
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [7:0]         cr1_q, cr1_d;
  logic [7:0]         cr2_q, cr2_d;
  logic [7:0]         br_q, br_d;
  logic               rxovf_q, rxovf_d;
  logic               irq_q, irq_d;
  logic [PTR_W-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PTR_W-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0]  tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  rx_mem_q [FIFO_DEPTH];

  logic access_ph, rdy, wr, rd;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, rx_pop, rx_push, rx_ovf_set, flush;
  logic spif, sptef;
  logic [7:0] sr_val, lvl_val;
  logic [DATA_W-1:0] rdata;
  logic rerr;

  // Bus phase decode and FIFO handshakes; every commit is qualified by the completing edge (rdy).
  always_comb begin
    access_ph  = PSEL & PENABLE & (state_q != IDLE);
    rdy        = access_ph & (wcnt_q == 2'd0);
    wr         = rdy & PWRITE;
    rd         = rdy & ~PWRITE;
    tx_empty   = (tx_cnt_q == '0);
    tx_full    = (tx_cnt_q == DEPTH_C);
    rx_empty   = (rx_cnt_q == '0);
    rx_full    = (rx_cnt_q == DEPTH_C);
    tx_pop     = ~tx_empty & cr1_q[6] & tx_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    tx_push    = wr & (PADDR == 3'd5) & (~tx_full | tx_pop);
    rx_pop     = rd & (PADDR == 3'd5) & ~rx_empty;
    rx_push    = rx_valid & (~rx_full | rx_pop);
    rx_ovf_set = rx_valid & rx_full & ~rx_pop;
    flush      = wr & (PADDR == 3'd0) & cr1_q[6] & ~PWDATA[6];
    spif       = ~rx_empty;
    sptef      = ~tx_full;
    sr_val     = {spif, rxovf_q, sptef, tx_empty, tip, 3'b000};
    lvl_val    = {4'(rx_cnt_q), 4'(tx_cnt_q)};
  end

  // Read mux and error decode for the currently addressed register.
  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    case (PADDR)
      3'd0: rdata = DATA_W'(cr1_q);
      3'd1: rdata = DATA_W'(cr2_q);
      3'd2: rdata = DATA_W'(br_q);
      3'd3: rdata = DATA_W'(sr_val);
      3'd4: begin
        rdata = DATA_W'(lvl_val);
        rerr  = PWRITE;
      end
      3'd5: begin
        if (PWRITE) begin
          rerr = tx_full & ~tx_pop;
        end else if (rx_empty) begin
          rerr = 1'b1;
        end else begin
          rdata = rx_mem_q[rx_rp_q];
        end
      end
      default: rerr = 1'b1;
    endcase
  end

  // APB completion outputs are only driven during the ready cycle.
  always_comb begin
    PREADY  = rdy;
    PRDATA  = rdy ? rdata : '0;
    PSLVERR = rdy & rerr;
  end

  // Next-state for the APB phase tracker, registers, status and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    cr1_d    = cr1_q;
    cr2_d    = cr2_q;
    br_d     = br_q;
    rxovf_d  = rxovf_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;

    // Back-to-back transfers re-enter SETUP from any state when a new setup phase appears.
    if (PSEL & ~PENABLE) begin
      state_d = SETUP;
      wcnt_d  = 2'(WAIT_STATES);
    end else if (access_ph) begin
      if (rdy) begin
        state_d = IDLE;
      end else begin
        state_d = ACCESS;
        wcnt_d  = wcnt_q - 2'd1;
      end
    end else if (~PSEL) begin
      state_d = IDLE;
    end

    if (wr) begin
      case (PADDR)
        3'd0: cr1_d = PWDATA[7:0];
        3'd1: cr2_d = PWDATA[7:0];
        3'd2: br_d  = PWDATA[7:0] & 8'h77;
        3'd3: if (PWDATA[6]) rxovf_d = 1'b0;
        default: ;
      endcase
    end
    if (rx_ovf_set) rxovf_d = 1'b1;

    tx_wp_d  = tx_wp_q + PTR_W'(tx_push);
    tx_rp_d  = tx_rp_q + PTR_W'(tx_pop);
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_wp_d  = rx_wp_q + PTR_W'(rx_push);
    rx_rp_d  = rx_rp_q + PTR_W'(rx_pop);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);

    // Disabling the core discards queued data in both directions; RXOVF survives.
    if (flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end

    irq_d = cr1_q[6] & ((cr1_q[7] & (spif | rxovf_q)) | (cr1_q[5] & sptef));
  end

  // State registers with asynchronous reset; reset mid-transfer drops any pending commit.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      wcnt_q   <= 2'd0;
      cr1_q    <= 8'h04;
      cr2_q    <= 8'h00;
      br_q     <= 8'h00;
      rxovf_q  <= 1'b0;
      irq_q    <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      cr1_q    <= cr1_d;
      cr2_q    <= cr2_d;
      br_q     <= br_d;
      rxovf_q  <= rxovf_d;
      irq_q    <= irq_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= PWDATA;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

  // Decoded control outputs and SPI mode selection.
  always_comb begin
    mstr     = cr1_q[4];
    cpol     = cr1_q[3];
    cpha     = cr1_q[2];
    lsbfe    = cr1_q[0];
    spe      = cr1_q[6];
    spiswai  = cr2_q[1];
    sppr     = br_q[6:4];
    spr      = br_q[2:0];
    tx_valid = ~tx_empty & cr1_q[6];
    tx_data  = tx_empty ? '0 : tx_mem_q[tx_rp_q];
    spi_interrupt_request = irq_q;
    if (~cr1_q[6])                     spi_mode = 2'b10;
    else if (cr2_q[1] & wait_req)      spi_mode = 2'b01;
    else                               spi_mode = 2'b00;
  end

endmodule

// File: doc/apb_spi_fifo_regs.md
# apb_spi_fifo_regs

Parametrised APB register slave for the SPI controller, successor to the single-byte register interface. Holds CR1, CR2 and BR, and exposes a read-only status and level register. Adds configurable-depth TX/RX FIFOs behind the data register, a configurable data width and programmable APB wait states. It sits between the APB bus and the SPI shift/baud core.

## Interface
- DATA_W, 8, SPI data width; legal values 8, 16, 32.
- FIFO_DEPTH, 4, entries per FIFO; legal values 2, 4, 8.
- WAIT_STATES, 0, extra access-phase cycles before PREADY; legal range 0..3.
- PCLK  in  1  single clock; everything is on its rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PADDR  in  3  register address.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data.
- PREADY, PSLVERR  out  1 each  APB completion and error.
- mstr, cpol, cpha, lsbfe, spiswai, spe  out  1 each  decoded CR1/CR2 bits.
- sppr, spr  out  3 each  baud prescaler and divider.
- spi_mode  out  2  mode: 00 run, 01 wait, 10 stop.
- wait_req  in  1  system wait-mode request.
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  TX FIFO is non-empty and spe=1.
- tx_ready  in  1  core pops the TX FIFO.
- rx_data  in  DATA_W  received word.
- rx_valid  in  1  one-cycle push into the RX FIFO.
- tip  in  1  transfer in progress.
- spi_interrupt_request  out  1  registered interrupt output.

## Operation
- Register map. Control registers use the low 8 bits; PRDATA upper bits read 0.
  - 0 CR1 = {SPIE, SPE, SPTIE, MSTR, CPOL, CPHA, SSOE, LSBFE}. Reset value 0x04.
  - 1 CR2: bit1 = SPISWAI; other bits are storage. Reset value 0x00.
  - 2 BR = {0, SPPR[2:0], 0, SPR[2:0]}. Reset value 0x00.
  - 3 SR = {SPIF (RX non-empty), RXOVF (sticky), SPTEF (TX not full), TXEMPTY, TIP, 000}. Writing 1 to bit6 clears RXOVF; all other bits are read-only and writes to them are ignored without error.
  - 4 LVL, read-only = {rx_count[3:0], tx_count[3:0]}. A write returns PSLVERR.
  - 5 DR. A write pushes the TX FIFO; a read pops the RX FIFO.
  - 6 and 7 are unmapped: PSLVERR, no state change, PRDATA=0.
- APB FSM states are IDLE, SETUP and ACCESS.
  - IDLE→SETUP on PSEL & !PENABLE.
  - SETUP→ACCESS on PENABLE; the wait counter loads WAIT_STATES.
  - In ACCESS, PREADY=1 once the counter reaches 0. The transfer completes on that edge; go to SETUP if PSEL is still high, otherwise IDLE.
- Write commit, register update and FIFO pop occur only on the completing edge.
- PRDATA and PSLVERR are driven combinationally while PREADY=1 and are 0 otherwise.
- DR write with TX full: PSLVERR, data dropped. DR read with RX empty: PSLVERR, PRDATA=0.
- TX pop occurs on tx_valid & tx_ready. tx_data is the FIFO head, 0 when empty.
- RX push on rx_valid:
  - If full, the data is dropped and RXOVF is set.
  - A pop and a push on the same edge is legal when the FIFO is full: count is unchanged, no overflow.
  - The same pop/push rule applies to TX on the same edge.
- A CR1 write that takes SPE from 1 to 0 flushes both FIFOs on the same edge. RXOVF is kept.
- spi_mode: 10 when !spe; 01 when spe & spiswai & wait_req; otherwise 00.
- Interrupt: spi_interrupt_request <= spe & ((SPIE & (SPIF | RXOVF)) | (SPTIE & SPTEF)). It is registered, one cycle behind the status bits.
- FIFO pointers wrap modulo FIFO_DEPTH. Counts run 0..FIFO_DEPTH.

## Timing
- Reset values:
  - All registers as listed above.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - cpha=1; all other control outputs 0; spi_mode=10.
  - Both FIFOs empty; tx_valid=0; interrupt 0; FSM in IDLE.
- PRESET mid-transfer aborts the transfer immediately: no commit and no pop.
- Minimum transfer length is 2+WAIT_STATES cycles: SETUP plus ACCESS.
- Register and FIFO effects are visible on the cycle after the completing edge.
- tx_valid deasserts on the cycle after the pop of the last entry.

## Test plan
- Reset with defaults: read CR1 → 0x04; read SR → 0x30 (SPTEF, TXEMPTY); spi_mode=10; each read takes 2 cycles with PSLVERR=0.
- CR1=0xD0, CR2=0x02, BR=0x12 → mstr=1, spe=1, spiswai=1, sppr=1, spr=2. Then raise wait_req → spi_mode=01.
- DATA_W=16, FIFO_DEPTH=4: write DR 0xA5A5, 0x1234, 0x5A5A, 0xFFFF. A fifth write gives PSLVERR. LVL reads 0x04. Pulsing tx_ready four times yields the words in order, then tx_valid=0.
- Five rx_valid pulses (0x3C..0x40) with depth 4 → SR bit6 set. DR reads return 0x3C..0x3F; a fifth read gives PSLVERR and 0. Writing SR=0x40 clears RXOVF.
- WAIT_STATES=2: a read completes after exactly 4 cycles with PREADY low for 2 ACCESS cycles. An access to address 7 gives PSLVERR=1.
- With SPIE=1, one rx push → interrupt high one cycle later. SPE 1→0 flush → LVL reads 0x00 and the interrupt drops.
